// File: rtl/tbus_mem_responder.sv
// rtl/tbus_mem_responder.sv - tbus responder over a 64-bit word array, fixed latency; optional TBUS_RESP_OOR_ERR_EN adds tbus_resp_err
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'd0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd1
`endif

module tbus_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tbus_index_valid,
  output logic                      tbus_index_ready,
  input  logic [63:0]               tbus_index,
  input  logic [63:0]               tbus_write_data,
  input  logic [63:0]               tbus_write_mask,
  input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
  output logic                      tbus_operation_done,
  output logic [63:0]               tbus_read_data,
  input  logic                      mem2dcache_flush
`ifdef TBUS_RESP_OOR_ERR_EN
  ,
  output logic                      tbus_resp_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  // BUSY lasts LATENCY-1 cycles so that RESP lands on cycle T+LATENCY;
  // with LATENCY==1 the access happens on the fire edge itself.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [AW-1:0] lat_word;
  logic          lat_write;
  logic          lat_oor;
  logic [63:0]   lat_wdata;
  logic [63:0]   lat_mask;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   read_data_q;

  logic          fire;
  logic          access;
  logic          req_write;
  logic          req_oor;
  logic [AW-1:0] req_word;
  logic [AW-1:0] acc_word;
  logic          acc_write;
  logic          acc_oor;
  logic [63:0]   acc_wdata;
  logic [63:0]   acc_mask;
  logic          unused_bits;

  assign tbus_index_ready    = (state_q == IDLE) & ~mem2dcache_flush;
  assign fire                = tbus_index_valid & tbus_index_ready;
  assign req_word            = tbus_index[AW+2:3];
  // Anything that is not an explicit WRITE behaves as a READ.
  assign req_write           = (tbus_operation_type == `TBUS_WRITE);
  assign tbus_operation_done = (state_q == RESP);
  assign tbus_read_data      = read_data_q;
  assign unused_bits         = ^{tbus_index[2:0], tbus_index[63:AW+3]};

`ifdef TBUS_RESP_OOR_ERR_EN
  assign req_oor = |tbus_index[63:AW+3];
`else
  assign req_oor = 1'b0;
`endif

  // Single-cycle latency accesses straight from the request; otherwise from the latched copy.
  assign acc_word  = (LATENCY == 1) ? req_word        : lat_word;
  assign acc_write = (LATENCY == 1) ? req_write       : lat_write;
  assign acc_oor   = (LATENCY == 1) ? req_oor         : lat_oor;
  assign acc_wdata = (LATENCY == 1) ? tbus_write_data : lat_wdata;
  assign acc_mask  = (LATENCY == 1) ? tbus_write_mask : lat_mask;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and the access strobe; a flush aborts only a latched READ.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem2dcache_flush && !lat_write) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) access = 1'b0;
  end

  // Latency counter: loaded on fire, counts down while BUSY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   cnt_q <= 4'd0;
    else if (fire)                               cnt_q <= CNT_INIT;
    else if (state_q == BUSY && cnt_q != 4'd0)   cnt_q <= cnt_q - 4'd1;
  end

  // Capture the request on fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_word  <= '0;
      lat_write <= 1'b0;
      lat_oor   <= 1'b0;
      lat_wdata <= '0;
      lat_mask  <= '0;
    end else if (fire) begin
      lat_word  <= req_word;
      lat_write <= req_write;
      lat_oor   <= req_oor;
      lat_wdata <= tbus_write_data;
      lat_mask  <= tbus_write_mask;
    end
  end

  // Bit-masked write into the array; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (access && acc_write && !acc_oor)
      mem[acc_word] <= (mem[acc_word] & ~acc_mask) | (acc_wdata & acc_mask);
  end

  // Read data register holds the last READ result until the next READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      read_data_q <= '0;
    else if (access && !acc_write)  read_data_q <= acc_oor ? 64'd0 : mem[acc_word];
  end

`ifdef TBUS_RESP_OOR_ERR_EN
  logic err_q;
  // Error flag is set only for the RESP cycle following an out-of-range access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= access & acc_oor;
  end
  assign tbus_resp_err = err_q;
`endif

endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb/tb_tbus_mem_responder.sv - directed bench with a cycle-level behavioural model of tbus_mem_responder
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'd0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd1
`endif

module tb_tbus_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int AW    = 8;

  logic clock = 1'b0;
  logic reset;
  logic tbus_index_valid;
  logic tbus_index_ready;
  logic [63:0] tbus_index;
  logic [63:0] tbus_write_data;
  logic [63:0] tbus_write_mask;
  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type;
  logic tbus_operation_done;
  logic [63:0] tbus_read_data;
  logic mem2dcache_flush;
`ifdef TBUS_RESP_OOR_ERR_EN
  logic tbus_resp_err;
`endif

  tbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock),
    .reset(reset),
    .tbus_index_valid(tbus_index_valid),
    .tbus_index_ready(tbus_index_ready),
    .tbus_index(tbus_index),
    .tbus_write_data(tbus_write_data),
    .tbus_write_mask(tbus_write_mask),
    .tbus_operation_type(tbus_operation_type),
    .tbus_operation_done(tbus_operation_done),
    .tbus_read_data(tbus_read_data),
    .mem2dcache_flush(mem2dcache_flush)
`ifdef TBUS_RESP_OOR_ERR_EN
    ,
    .tbus_resp_err(tbus_resp_err)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (tbus_operation_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: one outstanding request, completion at fire+LAT,
  // reads aborted by a flush strictly between fire and completion.
  logic [63:0] mdl [DEPTH];
  bit          started = 0;
  bit          pend = 0;
  int          p_t, c = 0;
  bit          p_wr, p_oor;
  int          p_word;
  logic [63:0] p_d, p_m;
  logic [63:0] exp_rd = 64'd0;
  bit          e_ready, e_done, e_err;

  always @(negedge clock) begin
    c++;
    if (reset) begin
      pend    = 0;
      exp_rd  = 64'd0;
      started = 1;
    end
    if (started) begin
      e_ready = !pend && !mem2dcache_flush;
      e_done  = pend && (c == p_t + LAT);
      e_err   = e_done && p_oor;
      if (e_done && !p_wr) exp_rd = p_oor ? 64'd0 : mdl[p_word];
      chk("ready", 64'(tbus_index_ready), 64'(e_ready));
      chk("done", 64'(tbus_operation_done), 64'(e_done));
      chk("read_data", tbus_read_data, exp_rd);
`ifdef TBUS_RESP_OOR_ERR_EN
      chk("resp_err", 64'(tbus_resp_err), 64'(e_err));
`endif
      if (!reset) begin
        if (pend) begin
          if (!p_wr && mem2dcache_flush && c > p_t && c < p_t + LAT) begin
            pend = 0;
          end else if (c == p_t + LAT) begin
            if (p_wr && !p_oor) mdl[p_word] = (mdl[p_word] & ~p_m) | (p_d & p_m);
            pend = 0;
          end
        end
        if (e_ready && tbus_index_valid) begin
          pend   = 1;
          p_t    = c;
          p_wr   = (tbus_operation_type == `TBUS_WRITE);
          p_word = int'((tbus_index >> 3) % 64'(DEPTH));
`ifdef TBUS_RESP_OOR_ERR_EN
          p_oor  = (tbus_index >> (AW + 3)) != 64'd0;
`else
          p_oor  = 0;
`endif
          p_d    = tbus_write_data;
          p_m    = tbus_write_mask;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [63:0] idx, input logic [63:0] d,
                        input logic [63:0] m, output int t);
    int n;
    tbus_index_valid    = 1'b1;
    tbus_operation_type = wr ? `TBUS_WRITE : `TBUS_READ;
    tbus_index          = idx;
    tbus_write_data     = d;
    tbus_write_mask     = m;
    n = 0;
    @(negedge clock);
    while (tbus_index_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("req_accept", 64'(tbus_index_ready), 64'd1);
    t = cyc;
    @(posedge clock);
    #1;
    tbus_index_valid = 1'b0;
  endtask

  task automatic wait_done(output int t, output logic [63:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (tbus_operation_done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", 64'(tbus_operation_done), 64'd1);
    t = cyc;
    d = tbus_read_data;
    @(posedge clock);
    #1;
  endtask

  int t0, t1, dc;
  int f [4];
  logic [63:0] rd;

  initial begin
    reset = 1'b1;
    tbus_index_valid = 1'b0;
    tbus_index = '0;
    tbus_write_data = '0;
    tbus_write_mask = '0;
    tbus_operation_type = `TBUS_READ;
    mem2dcache_flush = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(tbus_index_ready), 64'd1);
    chk("rst_done", 64'(tbus_operation_done), 64'd0);
    chk("rst_rdata", tbus_read_data, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Full write then read back.
    do_req(1'b1, 64'h40, 64'h1122334455667788, '1, t0);
    wait_done(t1, rd);
    chk("t1_wr_latency", 64'(t1 - t0), 64'd3);
    do_req(1'b0, 64'h40, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
    chk("t1_rd_latency", 64'(t1 - t0), 64'd3);
    chk("t1_rdata", rd, 64'h1122334455667788);

    // Partial mask merge.
    do_req(1'b1, 64'h40, 64'hAAAAAAAA_BBBBBBBB, 64'h00000000_FFFFFFFF, t0);
    wait_done(t1, rd);
    do_req(1'b0, 64'h47, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
    chk("t2_masked", rd, 64'h11223344BBBBBBBB);

    // Read aborted by flush one cycle after fire.
    dc = done_cnt;
    do_req(1'b0, 64'h40, 64'd0, 64'd0, t0);
    mem2dcache_flush = 1'b1;
    @(posedge clock); #1;
    mem2dcache_flush = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("t3_no_done", 64'(done_cnt - dc), 64'd0);
    do_req(1'b0, 64'h40, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
    chk("t3_unchanged", rd, 64'h11223344BBBBBBBB);

    // Write survives a flush.
    do_req(1'b1, 64'h80, 64'hDEADBEEFCAFEF00D, '1, t0);
    mem2dcache_flush = 1'b1;
    @(posedge clock); #1;
    mem2dcache_flush = 1'b0;
    wait_done(t1, rd);
    chk("t4_wr_latency", 64'(t1 - t0), 64'd3);
    do_req(1'b0, 64'h80, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
    chk("t4_rdata", rd, 64'hDEADBEEFCAFEF00D);

    // Valid with flush in IDLE is never accepted.
    dc = done_cnt;
    tbus_index_valid = 1'b1;
    tbus_operation_type = `TBUS_READ;
    tbus_index = 64'h48;
    mem2dcache_flush = 1'b1;
    @(negedge clock);
    chk("t4_vf_ready", 64'(tbus_index_ready), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    tbus_index_valid = 1'b0;
    mem2dcache_flush = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("t4_vf_no_done", 64'(done_cnt - dc), 64'd0);

    // Back-to-back reads with valid held high.
    do_req(1'b1, 64'h48, 64'h0123456789ABCDEF, '1, t0);
    wait_done(t1, rd);
    do_req(1'b1, 64'h50, 64'hFEDCBA9876543210, '1, t0);
    wait_done(t1, rd);
    dc = done_cnt;
    do_req(1'b0, 64'h40, 64'd0, 64'd0, f[0]);
    do_req(1'b0, 64'h48, 64'd0, 64'd0, f[1]);
    do_req(1'b0, 64'h50, 64'd0, 64'd0, f[2]);
    do_req(1'b0, 64'h80, 64'd0, 64'd0, f[3]);
    wait_done(t1, rd);
    for (int i = 1; i < 4; i++) chk("t5_spacing", 64'(f[i] - f[i-1]), 64'd4);
    chk("t5_last_latency", 64'(t1 - f[3]), 64'd3);
    chk("t5_done_count", 64'(done_cnt - dc), 64'd4);
    chk("t5_last_rdata", rd, 64'hDEADBEEFCAFEF00D);

    // Reset in the middle of a write.
    do_req(1'b1, 64'h40, 64'd0, '1, t0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_ready", 64'(tbus_index_ready), 64'd1);
    chk("t6_done", 64'(tbus_operation_done), 64'd0);
    chk("t6_rdata_cleared", tbus_read_data, 64'd0);
    repeat (4) @(posedge clock);
    #1;
    do_req(1'b0, 64'h40, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
    chk("t6_old_data", rd, 64'h11223344BBBBBBBB);

    // Upper index bits: error response with the macro, aliasing without it.
    do_req(1'b0, 64'h0000_0100_0000_0048, 64'd0, 64'd0, t0);
    wait_done(t1, rd);
`ifdef TBUS_RESP_OOR_ERR_EN
    chk("t6_oor_rdata", rd, 64'd0);
`else
    chk("t6_alias_rdata", rd, 64'h0123456789ABCDEF);
`endif

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
